// File: rtl/sdf_bf_stage.sv
// ---------------------------------------------------------------------------
// sdf_bf_stage
//
// Single-path delay-feedback radix-2 DIF butterfly stage, one coefficient per
// clock. Works together with an external delay line (fifo) of depth DELAY
// that advances every cycle. A frame is 2*DELAY samples:
//   - load phase    (cnt <  DELAY): incoming samples are written into the
//                                   delay line; the previous frame's
//                                   differences come back out and are emitted.
//   - compute phase (cnt >= DELAY): a = delayed sample, b = new sample;
//                                   (a+b) mod Q is emitted and (a-b) mod Q is
//                                   written into the delay line.
//   - drain         (DELAY cycles): flushes the last frame's differences.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_data    input stream; in_ready is low only while draining
//   fb_wdata            combinational write data to the delay line
//   fb_rdata            delay line output (fb_wdata from DELAY cycles ago)
//   out_valid/out_data  registered output stream (sums, then differences)
//   err                 sticky flag: sample missing in the middle of a frame
// ---------------------------------------------------------------------------
module sdf_bf_stage #(
    parameter int WIDTH = 12,
    parameter int Q     = 3329,
    parameter int DELAY = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] fb_wdata,
    input  logic [WIDTH-1:0] fb_rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             err
);

    localparam int             CW         = $clog2(2 * DELAY);
    localparam logic [CW-1:0]  CNT_LAST   = CW'(2 * DELAY - 1);
    localparam logic [CW-1:0]  CNT_HALF   = CW'(DELAY);
    localparam logic [CW-1:0]  DRAIN_LAST = CW'(DELAY - 1);
    localparam logic [WIDTH:0] QW         = (WIDTH + 1)'(Q);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              have_prev_q, have_prev_d;
    logic              err_q, err_d;
    logic              out_valid_q;
    logic [WIDTH-1:0]  out_data_q;

    logic [WIDTH-1:0]  b_eff;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH-1:0]  sum_mod;
    logic [WIDTH-1:0]  diff_mod;
    logic [WIDTH-1:0]  cand_data;
    logic              cand_valid;
    logic              drain_now;

    // A missing sample mid-frame is treated as zero so the frame stays aligned.
    assign b_eff    = in_valid ? in_data : '0;
    assign sum_ext  = {1'b0, fb_rdata} + {1'b0, b_eff};
    assign diff_ext = {1'b0, fb_rdata} - {1'b0, b_eff};
    assign sum_mod  = (sum_ext >= QW) ? WIDTH'(sum_ext - QW) : sum_ext[WIDTH-1:0];
    // Borrow out of the extended subtraction marks a negative difference.
    assign diff_mod = diff_ext[WIDTH] ? WIDTH'(diff_ext + QW) : diff_ext[WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        have_prev_d = have_prev_q;
        err_d       = err_q;
        fb_wdata    = '0;
        cand_data   = fb_rdata;
        cand_valid  = 1'b0;
        in_ready    = 1'b1;

        // The cycle after a full frame is where run-vs-drain is decided: with
        // no new sample it already is drain cycle 0, so the first difference
        // (which arrives from the delay line in exactly that cycle) is not lost.
        drain_now = (state_q == DRAIN) ||
                    ((state_q == RUN) && (cnt_q == '0) && !in_valid);

        if (drain_now) begin
            in_ready   = 1'b0;
            cand_valid = 1'b1;
            if (cnt_q == DRAIN_LAST) begin
                state_d     = IDLE;
                cnt_d       = '0;
                have_prev_d = 1'b0;
            end else begin
                state_d = DRAIN;
                cnt_d   = cnt_q + CW'(1);
            end
        end else if ((state_q == RUN) || in_valid) begin
            // Covers RUN and the IDLE cycle that starts a frame (cnt is 0).
            if (!in_valid) begin
                err_d = 1'b1;
            end
            if (cnt_q < CNT_HALF) begin
                fb_wdata   = b_eff;
                cand_valid = have_prev_q;
            end else begin
                fb_wdata   = diff_mod;
                cand_data  = sum_mod;
                cand_valid = 1'b1;
            end
            state_d = RUN;
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                have_prev_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            have_prev_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            have_prev_q <= have_prev_d;
            err_q       <= err_d;
            out_valid_q <= cand_valid;
            if (cand_valid) begin
                out_data_q <= cand_data;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// ---------------------------------------------------------------------------
// tb_sdf_bf_stage
//
// Two stages under test: DELAY=4 for table-driven directed frames and the
// multi-cycle corner cases, DELAY=128 for random frames with random gaps.
// Each stage has a behavioural delay line (shift register, never reset).
// Expected outputs are queued when a frame is driven and popped as the
// stage emits them.
// ---------------------------------------------------------------------------
module tb_sdf_bf_stage;

    localparam int W  = 12;
    localparam int QM = 3329;
    localparam int DA = 4;
    localparam int DB = 128;

    logic         clk;
    logic         rst_n;

    logic         a_in_valid, a_in_ready, a_out_valid, a_err;
    logic [W-1:0] a_in_data, a_fb_wdata, a_fb_rdata, a_out_data;
    logic         b_in_valid, b_in_ready, b_out_valid, b_err;
    logic [W-1:0] b_in_data, b_fb_wdata, b_fb_rdata, b_out_data;

    logic [W-1:0] a_fifo [DA];
    logic [W-1:0] b_fifo [DB];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int a_vcnt, a_first, a_last, a_rdy_low;
    int k0;

    logic [W-1:0] exp_a [$];
    logic [W-1:0] exp_b [$];

    typedef struct {
        logic [W-1:0] x [8];
        logic [W-1:0] y [8];
    } vec_t;

    vec_t         tbl [4];
    logic [W-1:0] perr_y [8];
    int           bfr [2*DB];

    sdf_bf_stage #(.WIDTH(W), .Q(QM), .DELAY(DA)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .fb_wdata  (a_fb_wdata),
        .fb_rdata  (a_fb_rdata),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .err       (a_err)
    );

    sdf_bf_stage #(.WIDTH(W), .Q(QM), .DELAY(DB)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .fb_wdata  (b_fb_wdata),
        .fb_rdata  (b_fb_rdata),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .err       (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay lines: fb_rdata in cycle t is fb_wdata of cycle t-DELAY.
    always @(posedge clk) begin
        a_fifo[0] <= a_fb_wdata;
        for (int i = 1; i < DA; i++) a_fifo[i] <= a_fifo[i-1];
        b_fifo[0] <= b_fb_wdata;
        for (int i = 1; i < DB; i++) b_fifo[i] <= b_fifo[i-1];
    end
    assign a_fb_rdata = a_fifo[DA-1];
    assign b_fb_rdata = b_fifo[DB-1];

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d (cyc %0d)", name, got, req, cyc);
        end
    endtask

    task automatic mon();
        logic [W-1:0] e;
        if (!a_in_ready) a_rdy_low++;
        if (a_out_valid) begin
            a_vcnt++;
            if (a_first < 0) a_first = cyc;
            a_last = cyc;
            if (exp_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_out got=%0d required=no output (cyc %0d)", a_out_data, cyc);
            end else begin
                e = exp_a.pop_front();
                $display("A out cyc=%0d data=%0d exp=%0d", cyc, a_out_data, e);
                check("a_out_data", int'(a_out_data), int'(e));
            end
        end
        if (b_out_valid) begin
            if (exp_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_out got=%0d required=no output (cyc %0d)", b_out_data, cyc);
            end else begin
                e = exp_b.pop_front();
                check("b_out_data", int'(b_out_data), int'(e));
            end
        end
    endtask

    // One clock: sample outputs on the falling edge, then advance past the
    // rising edge so the caller can drive the next cycle's inputs.
    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic win_clear();
        a_vcnt    = 0;
        a_first   = -1;
        a_last    = -1;
        a_rdy_low = 0;
    endtask

    task automatic drive_a_frame(input logic [W-1:0] x [8], input int hole);
        for (int i = 0; i < 8; i++) begin
            a_in_valid = (i != hole);
            a_in_data  = (i != hole) ? x[i] : W'(99);
            step();
        end
    endtask

    // Drain plus a few idle cycles; optionally offers junk while in_ready is low.
    task automatic drain_a(input bit poke);
        for (int j = 0; j < DA + 3; j++) begin
            a_in_valid = poke && (j >= 1) && (j <= DA - 1);
            a_in_data  = W'(2748);
            step();
        end
        a_in_valid = 1'b0;
    endtask

    initial begin
        int gap;
        int wait_cnt;

        tbl[0].x = '{1, 2, 3, 4, 5, 6, 7, 8};
        tbl[0].y = '{6, 8, 10, 12, 3325, 3325, 3325, 3325};
        tbl[1].x = '{3328, 0, 5, 3328, 3328, 1, 3328, 0};
        tbl[1].y = '{3327, 1, 4, 3328, 0, 3328, 6, 3328};
        tbl[2].x = '{100, 200, 300, 400, 50, 250, 300, 1000};
        tbl[2].y = '{150, 450, 600, 1400, 50, 3279, 0, 2729};
        tbl[3].x = '{3000, 3000, 1, 2, 3000, 329, 3328, 3328};
        tbl[3].y = '{2671, 0, 0, 1, 0, 2671, 2, 3};
        // x = 1..8 with the sample at cnt=2 missing (taken as 0)
        perr_y   = '{6, 8, 7, 12, 3325, 3325, 3322, 3325};

        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        a_in_data  = '0;
        b_in_valid = 1'b0;
        b_in_data  = '0;
        win_clear();
        repeat (3) step();

        check("rst_a_out_valid", int'(a_out_valid), 0);
        check("rst_a_out_data",  int'(a_out_data), 0);
        check("rst_a_err",       int'(a_err), 0);
        check("rst_a_in_ready",  int'(a_in_ready), 1);
        check("rst_b_out_valid", int'(b_out_valid), 0);
        check("rst_b_in_ready",  int'(b_in_ready), 1);
        rst_n = 1'b1;
        step();

        // Table-driven single frames, each followed by a drain.
        for (int v = 0; v < 4; v++) begin
            win_clear();
            k0 = cyc;
            for (int i = 0; i < 8; i++) exp_a.push_back(tbl[v].y[i]);
            drive_a_frame(tbl[v].x, -1);
            drain_a(v % 2 == 1);
            check("vec_valid_count", a_vcnt, 2 * DA);
            check("vec_first_valid", a_first, k0 + DA + 1);
            check("vec_last_valid",  a_last, k0 + 3 * DA);
            check("vec_ready_low",   a_rdy_low, DA);
            check("vec_err",         int'(a_err), 0);
            check("vec_queue_empty", exp_a.size(), 0);
            $display("A vector %0d frame done outputs=%0d", v, a_vcnt);
        end

        // Back-to-back frames: no drain between them, continuous output.
        win_clear();
        k0 = cyc;
        for (int i = 0; i < 8; i++) exp_a.push_back(tbl[1].y[i]);
        for (int i = 0; i < 8; i++) exp_a.push_back(tbl[2].y[i]);
        drive_a_frame(tbl[1].x, -1);
        drive_a_frame(tbl[2].x, -1);
        drain_a(1'b0);
        check("b2b_valid_count", a_vcnt, 4 * DA);
        check("b2b_first_valid", a_first, k0 + DA + 1);
        check("b2b_last_valid",  a_last, k0 + 5 * DA);
        check("b2b_ready_low",   a_rdy_low, DA);
        check("b2b_queue_empty", exp_a.size(), 0);
        $display("A back-to-back done outputs=%0d", a_vcnt);

        // Protocol error: sample missing at cnt=2.
        win_clear();
        for (int i = 0; i < 8; i++) exp_a.push_back(perr_y[i]);
        drive_a_frame(tbl[0].x, 2);
        check("perr_err_set", int'(a_err), 1);
        drain_a(1'b0);
        check("perr_err_sticky",  int'(a_err), 1);
        check("perr_valid_count", a_vcnt, 2 * DA);
        check("perr_queue_empty", exp_a.size(), 0);
        $display("A protocol-error frame done outputs=%0d", a_vcnt);

        // Reset mid-frame at cnt=5; nothing from this frame is queued.
        win_clear();
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = tbl[0].x[i];
            step();
        end
        check("prerst_out_valid", int'(a_out_valid), 1);
        check("prerst_out_data",  int'(a_out_data), 6);
        a_in_data = tbl[0].x[5];
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(a_out_valid), 0);
        check("midrst_out_data",  int'(a_out_data), 0);
        check("midrst_err",       int'(a_err), 0);
        check("midrst_in_ready",  int'(a_in_ready), 1);
        a_in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        win_clear();
        k0 = cyc;
        for (int i = 0; i < 8; i++) exp_a.push_back(tbl[3].y[i]);
        drive_a_frame(tbl[3].x, -1);
        drain_a(1'b0);
        check("postrst_valid_count", a_vcnt, 2 * DA);
        check("postrst_first_valid", a_first, k0 + DA + 1);
        check("postrst_queue_empty", exp_a.size(), 0);
        $display("A post-reset frame done outputs=%0d", a_vcnt);

        // Random frames on the DELAY=128 stage with random gaps.
        for (int f = 0; f < 20; f++) begin
            if (f == 0) gap = 0;
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = int'($urandom_range(1, 200));
            if (gap > 0) begin
                b_in_valid = 1'b0;
                repeat (gap) step();
                wait_cnt = 0;
                while (!b_in_ready && wait_cnt < 1000) begin
                    step();
                    wait_cnt++;
                end
                check("b_ready_wait_bound", int'(wait_cnt < 1000), 1);
            end
            for (int i = 0; i < 2 * DB; i++) bfr[i] = int'($urandom_range(0, QM - 1));
            for (int i = 0; i < DB; i++) exp_b.push_back(W'((bfr[i] + bfr[i+DB]) % QM));
            for (int i = 0; i < DB; i++) exp_b.push_back(W'((bfr[i] - bfr[i+DB] + QM) % QM));
            for (int i = 0; i < 2 * DB; i++) begin
                b_in_valid = 1'b1;
                b_in_data  = W'(bfr[i]);
                step();
            end
            $display("B frame %0d driven gap=%0d pending=%0d", f, gap, exp_b.size());
        end
        b_in_valid = 1'b0;
        wait_cnt = 0;
        while ((exp_b.size() > 0 || exp_a.size() > 0) && wait_cnt < 1000) begin
            step();
            wait_cnt++;
        end
        repeat (3) step();
        check("b_queue_empty", exp_b.size(), 0);
        check("a_queue_empty", exp_a.size(), 0);
        check("b_err", int'(b_err), 0);
        check("b_in_ready_idle", int'(b_in_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
